// File: rtl/fft8_engine.sv
// 8-point radix-2 DIT FFT/IFFT engine: bit-reversed LOAD, one butterfly per RUN cycle,
// 1/2 scaling per stage, natural-order EXPORT of 16-bit fields sign-extended to 32 bits.
module fft8_engine (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  input  logic [1:0]  cmd_op,
  input  logic [3:0]  cmd_sel,
  input  logic [31:0] cmd_data,
  output logic        cmd_ready,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        result_valid
);

  localparam logic [1:0] OP_LOAD   = 2'd0;
  localparam logic [1:0] OP_FFT    = 2'd1;
  localparam logic [1:0] OP_EXPORT = 2'd2;
  localparam logic [1:0] OP_IFFT   = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             r_state;
  logic [1:0]         r_n;
  logic [1:0]         r_stage;
  logic               r_inv;
  logic               r_ready;
  logic               r_busy;
  logic               r_done;
  logic               r_rv;
  logic [31:0]        r_result;
  logic signed [15:0] r_re [8];
  logic signed [15:0] r_im [8];

  logic               w_accept;
  logic [2:0]         w_ld_idx;
  logic [2:0]         w_top;
  logic [2:0]         w_bot;
  logic [1:0]         w_widx;
  logic signed [15:0] w_wr;
  logic signed [15:0] w_wi;
  logic signed [31:0] w_br32, w_bi32, w_wr32, w_wi32;
  logic signed [31:0] w_tr_full, w_ti_full;
  logic signed [16:0] w_tr17, w_ti17;

  function automatic logic signed [15:0] tw_re(input logic [1:0] idx);
    case (idx)
      2'd0:    return 16'sd16384;
      2'd1:    return 16'sd11585;
      2'd2:    return 16'sd0;
      default: return -16'sd11585;
    endcase
  endfunction

  // IFFT uses the conjugate twiddle, so only the imaginary part flips.
  function automatic logic signed [15:0] tw_im(input logic [1:0] idx, input logic inv);
    logic signed [15:0] v;
    case (idx)
      2'd0:    v = 16'sd0;
      2'd1:    v = -16'sd11585;
      2'd2:    v = -16'sd16384;
      default: v = -16'sd11585;
    endcase
    return inv ? -v : v;
  endfunction

  // (a +/- t) in 17 bits, floor-halved and truncated back to 16 bits.
  function automatic logic signed [15:0] bfly_half(input logic signed [15:0] a,
                                                   input logic signed [16:0] t,
                                                   input logic sub);
    logic signed [16:0] a17;
    logic signed [16:0] s;
    a17 = {a[15], a};
    s   = sub ? (a17 - t) : (a17 + t);
    return s[16:1];
  endfunction

  assign w_accept = cmd_valid & r_ready;
  assign w_ld_idx = {cmd_sel[0], cmd_sel[1], cmd_sel[2]};

  // Stage s: h = 2^(s-1); top = (n div h)*2h + (n mod h); twiddle index = (n mod h)*4/h.
  always_comb begin
    w_top  = 3'd0;
    w_bot  = 3'd0;
    w_widx = 2'd0;
    case (r_stage)
      2'd1: begin w_top = {r_n, 1'b0};             w_bot = w_top | 3'd1; w_widx = 2'd0;            end
      2'd2: begin w_top = {r_n[1], 1'b0, r_n[0]};  w_bot = w_top | 3'd2; w_widx = {r_n[0], 1'b0};  end
      2'd3: begin w_top = {1'b0, r_n};             w_bot = w_top | 3'd4; w_widx = r_n;             end
      default: ;
    endcase
  end

  assign w_wr      = tw_re(w_widx);
  assign w_wi      = tw_im(w_widx, r_inv);
  assign w_br32    = 32'(r_re[w_bot]);
  assign w_bi32    = 32'(r_im[w_bot]);
  assign w_wr32    = 32'(w_wr);
  assign w_wi32    = 32'(w_wi);
  assign w_tr_full = w_br32 * w_wr32 - w_bi32 * w_wi32;
  assign w_ti_full = w_br32 * w_wi32 + w_bi32 * w_wr32;
  assign w_tr17    = 17'(w_tr_full >>> 14);
  assign w_ti17    = 17'(w_ti_full >>> 14);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        r_re[i] <= '0;
        r_im[i] <= '0;
      end
    end else if (w_accept && cmd_op == OP_LOAD) begin
      r_re[w_ld_idx] <= cmd_data[31:16];
      r_im[w_ld_idx] <= cmd_data[15:0];
    end else if (r_state == S_RUN) begin
      r_re[w_top] <= bfly_half(r_re[w_top], w_tr17, 1'b0);
      r_im[w_top] <= bfly_half(r_im[w_top], w_ti17, 1'b0);
      r_re[w_bot] <= bfly_half(r_re[w_top], w_tr17, 1'b1);
      r_im[w_bot] <= bfly_half(r_im[w_top], w_ti17, 1'b1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_n      <= 2'd0;
      r_stage  <= 2'd0;
      r_inv    <= 1'b0;
      r_ready  <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_rv     <= 1'b0;
      r_result <= '0;
    end else begin
      r_rv <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            case (cmd_op)
              OP_EXPORT: begin
                r_result <= cmd_sel[3] ? {{16{r_im[cmd_sel[2:0]][15]}}, r_im[cmd_sel[2:0]]}
                                       : {{16{r_re[cmd_sel[2:0]][15]}}, r_re[cmd_sel[2:0]]};
                r_rv     <= 1'b1;
              end
              OP_FFT, OP_IFFT: begin
                r_inv   <= (cmd_op == OP_IFFT);
                r_n     <= 2'd0;
                r_ready <= 1'b0;
                r_busy  <= 1'b1;
                // Out-of-range stage codes complete immediately without touching the slots.
                if (cmd_sel[3:2] == 2'b00 && cmd_sel[1:0] != 2'b00) begin
                  r_stage <= cmd_sel[1:0];
                  r_state <= S_RUN;
                end else begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
        S_RUN: begin
          r_n <= r_n + 2'd1;
          if (r_n == 2'd3) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready    = r_ready;
  assign busy         = r_busy;
  assign done         = r_done;
  assign result       = r_result;
  assign result_valid = r_rv;

endmodule

// File: tb/tb_fft8_engine.sv
// Scoreboard bench for fft8_engine: directed spec vectors plus randomized data
// against an array-based reference FFT built from the stage/butterfly index rules.
module tb_fft8_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = 2'd0;
  logic [3:0]  cmd_sel = 4'd0;
  logic [31:0] cmd_data = 32'd0;
  logic        cmd_ready, busy, done, result_valid;
  logic [31:0] result;

  fft8_engine dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_sel(cmd_sel),
    .cmd_data(cmd_data), .cmd_ready(cmd_ready), .busy(busy), .done(done),
    .result(result), .result_valid(result_valid)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  string       nm_q[$];
  int          mre[8];
  int          mim[8];
  int          TWR[4] = '{16384, 11585, 0, -11585};
  int          TWI[4] = '{0, -11585, -16384, -11585};

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
    end
  endtask

  function automatic int s16(input int v);
    logic signed [15:0] t;
    t = v[15:0];
    return int'(t);
  endfunction

  function automatic int bitrev3(input int k);
    return ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
  endfunction

  // Reference stage: plain integer arithmetic over the 8-entry arrays.
  task automatic model_stage(input int s, input bit inv);
    int h, j, g, top, bot, w, wr, wi, tr, ti, ar, ai;
    h = 1 << (s - 1);
    for (int n = 0; n < 4; n++) begin
      j = n % h; g = n / h;
      top = g * 2 * h + j; bot = top + h;
      w = j * 4 / h;
      wr = TWR[w]; wi = inv ? -TWI[w] : TWI[w];
      tr = (mre[bot] * wr - mim[bot] * wi) >>> 14;
      ti = (mre[bot] * wi + mim[bot] * wr) >>> 14;
      ar = mre[top]; ai = mim[top];
      mre[top] = s16((ar + tr) >>> 1); mim[top] = s16((ai + ti) >>> 1);
      mre[bot] = s16((ar - tr) >>> 1); mim[bot] = s16((ai - ti) >>> 1);
    end
  endtask

  // Monitor: every result_valid pulse is matched against the oldest pending expectation.
  always @(posedge clk) begin
    #1;
    if (result_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_result actual=0x%08h required=none", result);
      end else begin
        check(nm_q.pop_front(), result, exp_q.pop_front());
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [3:0] sel, input logic [31:0] data);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_sel = sel; cmd_data = data;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic load(input int k, input int re, input int im);
    logic [15:0] r16, i16;
    r16 = re[15:0]; i16 = im[15:0];
    issue(2'd0, 4'(k), {r16, i16});
    mre[bitrev3(k)] = s16(re);
    mim[bitrev3(k)] = s16(im);
  endtask

  task automatic export_exp(input int k, input bit part, input int expv);
    exp_q.push_back(32'(expv));
    nm_q.push_back($sformatf("export_k%0d_%s", k, part ? "im" : "re"));
    issue(2'd2, {part, 3'(k)}, 32'd0);
    check("result_valid_pulse", {31'd0, result_valid}, 32'd1);
  endtask

  task automatic export_all_model();
    for (int k = 0; k < 8; k++) begin
      export_exp(k, 1'b0, mre[k]);
      export_exp(k, 1'b1, mim[k]);
    end
  endtask

  task automatic cal(input bit inv, input int stage, input int exp_lat, input bit stall);
    int lat;
    issue(inv ? 2'd3 : 2'd1, 4'(stage), 32'd0);
    lat = 1;
    if (stall) begin
      check("stall_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      cmd_valid = 1'b1; cmd_op = 2'd0; cmd_sel = 4'd2; cmd_data = 32'h7FFF0000;
    end
    while (done !== 1'b1 && lat < 12) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      lat++;
    end
    check($sformatf("cal_latency_s%0d", stage), 32'(lat), 32'(exp_lat));
    check("busy_with_done", {31'd0, busy}, 32'd1);
    if (stage >= 1 && stage <= 3) model_stage(stage, inv);
    for (int i = 0; i < 4 && cmd_ready !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    check("ready_after_done", {31'd0, cmd_ready}, 32'd1);
  endtask

  initial begin
    for (int k = 0; k < 8; k++) begin mre[k] = 0; mim[k] = 0; end

    // Outputs while reset is held
    #12;
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_result_valid", {31'd0, result_valid}, 32'd0);
    @(negedge clk); rst = 1'b0;

    // Impulse
    load(0, 8192, 0);
    for (int k = 1; k < 8; k++) load(k, 0, 0);
    for (int s = 1; s <= 3; s++) cal(1'b0, s, 5, 1'b0);
    for (int k = 0; k < 8; k++) begin
      export_exp(k, 1'b0, 1024);
      export_exp(k, 1'b1, 0);
    end

    // Round trip of the impulse spectrum
    for (int k = 0; k < 8; k++) load(k, 1024, 0);
    for (int s = 1; s <= 3; s++) cal(1'b1, s, 5, 1'b0);
    for (int k = 0; k < 8; k++) begin
      export_exp(k, 1'b0, (k == 0) ? 1024 : 0);
      export_exp(k, 1'b1, 0);
    end

    // DC
    for (int k = 0; k < 8; k++) load(k, 8192, 0);
    for (int s = 1; s <= 3; s++) cal(1'b0, s, 5, 1'b0);
    for (int k = 0; k < 8; k++) begin
      export_exp(k, 1'b0, (k == 0) ? 8192 : 0);
      export_exp(k, 1'b1, 0);
    end

    // Randomized data against the reference model
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 8; k++)
        load(k, int'($urandom_range(24000)) - 12000, int'($urandom_range(24000)) - 12000);
      for (int s = 1; s <= 3; s++) cal(r[0], s, 5, 1'b0);
      export_all_model();
    end

    // Invalid stage codes leave the slots untouched
    cal(1'b0, 0, 1, 1'b0);
    cal(1'b1, 7, 1, 1'b0);
    export_all_model();

    // LOAD attempted while RUN must be ignored
    for (int k = 0; k < 8; k++) load(k, int'($urandom_range(8000)) - 4000, int'($urandom_range(8000)) - 4000);
    cal(1'b0, 1, 5, 1'b1);
    export_all_model();

    // Reset in the middle of a CAL
    issue(2'd1, 4'd1, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("midrst_no_done", {31'd0, done}, 32'd0);
    end
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 8; k++) begin mre[k] = 0; mim[k] = 0; end
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("postrst_no_done", {31'd0, done}, 32'd0);
    end
    export_exp(0, 1'b0, 0);
    export_exp(0, 1'b1, 0);
    export_exp(4, 1'b0, 0);

    repeat (4) @(posedge clk);
    #2;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
